// File: rtl/trace_feeder.sv
// Trace feeder: FIFO-buffered stream of trace addresses presented one at a time
// to the cache core, with a new-access strobe, hold timeout and access statistics.
module trace_feeder #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DEPTH       = 16,
  parameter int HOLD_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  fifo_count,
  input  logic                    start,
  input  logic                    access_done,
  output logic [ADDR_WIDTH-1:0]   memory_trace,
  output logic                    new_access,
  output logic                    busy,
  output logic [15:0]             access_count,
  output logic [15:0]             timeout_count
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int HOLD_W = $clog2(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_e;

  state_e                  state_q, state_d;
  logic [IDX_W:0]          wr_ptr_q, wr_ptr_d;
  logic [IDX_W:0]          rd_ptr_q, rd_ptr_d;
  logic [HOLD_W-1:0]       hold_q, hold_d;
  logic [ADDR_WIDTH-1:0]   trace_q, trace_d;
  logic [15:0]             acc_cnt_q, acc_cnt_d;
  logic [15:0]             tmo_cnt_q, tmo_cnt_d;
  logic                    new_access_q;
  logic                    pop;
  logic                    push;

  logic [ADDR_WIDTH-1:0]   mem_q [DEPTH];

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty      = (wr_ptr_q == rd_ptr_q);
  assign full       = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                      (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
  assign fifo_count = wr_ptr_q - rd_ptr_q;

  // A pop frees a slot in the same edge, so a push into a full FIFO is kept then.
  assign push     = wr_en && (!full || pop);
  assign wr_ptr_d = wr_ptr_q + (IDX_W+1)'(push);
  assign rd_ptr_d = rd_ptr_q + (IDX_W+1)'(pop);

  // NOTE: storage has no reset; flushing is done by clearing the pointers,
  // which keeps the array mappable to plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[IDX_W-1:0]] <= wr_addr;
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case leaves one unassigned (which would infer a latch).
    state_d   = state_q;
    hold_d    = hold_q;
    trace_d   = trace_q;
    acc_cnt_d = acc_cnt_q;
    tmo_cnt_d = tmo_cnt_q;
    pop       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start && !empty) begin
          pop       = 1'b1;
          trace_d   = mem_q[rd_ptr_q[IDX_W-1:0]];
          acc_cnt_d = acc_cnt_q + 16'd1;
          hold_d    = HOLD_LOAD;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (access_done) begin
          state_d = S_IDLE;
        end else if (hold_q == '0) begin
          if (tmo_cnt_q != 16'hFFFF) begin
            tmo_cnt_d = tmo_cnt_q + 16'd1;
          end
          state_d = S_IDLE;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      hold_q       <= '0;
      trace_q      <= '0;
      acc_cnt_q    <= '0;
      tmo_cnt_q    <= '0;
      new_access_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      hold_q       <= hold_d;
      trace_q      <= trace_d;
      acc_cnt_q    <= acc_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      new_access_q <= pop;
    end
  end

  assign memory_trace  = trace_q;
  assign new_access    = new_access_q;
  assign busy          = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign access_count  = acc_cnt_q;
  assign timeout_count = tmo_cnt_q;

endmodule

// File: tb/tb_trace_feeder.sv
// Directed self-checking bench for trace_feeder with default parameters
// (ADDR_WIDTH=16, DEPTH=16, HOLD_CYCLES=8).
module tb_trace_feeder;

  logic        clk;
  logic        reset_n;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic        full;
  logic        empty;
  logic [4:0]  fifo_count;
  logic        start;
  logic        access_done;
  logic [15:0] memory_trace;
  logic        new_access;
  logic        busy;
  logic [15:0] access_count;
  logic [15:0] timeout_count;

  int n_cmp = 0;
  int n_err = 0;
  int strobe_cnt = 0;
  int strobe_base;
  int busy_cycles;

  trace_feeder dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .full          (full),
    .empty         (empty),
    .fifo_count    (fifo_count),
    .start         (start),
    .access_done   (access_done),
    .memory_trace  (memory_trace),
    .new_access    (new_access),
    .busy          (busy),
    .access_count  (access_count),
    .timeout_count (timeout_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobes are counted mid-cycle, so a one-cycle pulse counts exactly once.
  always @(negedge clk) begin
    if (reset_n && new_access) strobe_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000ns");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full access from IDLE: pop, ISSUE, WAIT, access_done two cycles after the strobe.
  task automatic serve(input logic [15:0] exp_addr, input logic [15:0] exp_cnt);
    check("serve_idle_busy", 32'(busy), 32'd0);
    tick();
    check("serve_strobe", 32'(new_access), 32'd1);
    check("serve_addr", 32'(memory_trace), 32'(exp_addr));
    check("serve_busy_issue", 32'(busy), 32'd1);
    check("serve_acc_cnt", 32'(access_count), 32'(exp_cnt));
    tick();
    check("serve_strobe_low", 32'(new_access), 32'd0);
    check("serve_busy_wait", 32'(busy), 32'd1);
    access_done = 1'b1;
    tick();
    access_done = 1'b0;
    check("serve_done_idle", 32'(busy), 32'd0);
    check("serve_addr_held", 32'(memory_trace), 32'(exp_addr));
  endtask

  initial begin
    reset_n     = 1'b0;
    wr_en       = 1'b0;
    wr_addr     = '0;
    start       = 1'b0;
    access_done = 1'b0;
    #3;
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_trace", 32'(memory_trace), 32'd0);
    check("rst_strobe", 32'(new_access), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_acc", 32'(access_count), 32'd0);
    check("rst_tmo", 32'(timeout_count), 32'd0);
    #4 reset_n = 1'b1;
    tick();

    // Basic feed: 0010, 0014, 0010.
    wr_en = 1'b1; wr_addr = 16'h0010; tick();
    wr_addr = 16'h0014; tick();
    wr_addr = 16'h0010; tick();
    wr_en = 1'b0;
    check("feed_count", 32'(fifo_count), 32'd3);
    strobe_base = strobe_cnt;
    start = 1'b1;
    serve(16'h0010, 16'd1);
    serve(16'h0014, 16'd2);
    serve(16'h0010, 16'd3);
    check("feed_strobes", 32'(strobe_cnt - strobe_base), 32'd3);
    check("feed_tmo", 32'(timeout_count), 32'd0);
    check("feed_empty", 32'(empty), 32'd1);

    // Repeated identical address still yields two accesses (counts are cumulative).
    start = 1'b0;
    wr_en = 1'b1; wr_addr = 16'h00A0; tick();
    tick();
    wr_en = 1'b0;
    strobe_base = strobe_cnt;
    start = 1'b1;
    serve(16'h00A0, 16'd4);
    serve(16'h00A0, 16'd5);
    check("rep_strobes", 32'(strobe_cnt - strobe_base), 32'd2);

    // Timeout: no access_done, busy for ISSUE + 8 WAIT cycles.
    wr_en = 1'b1; wr_addr = 16'h1234; tick();
    wr_en = 1'b0;
    check("tmo_no_fallthrough", 32'(busy), 32'd0);
    tick();
    check("tmo_strobe", 32'(new_access), 32'd1);
    check("tmo_addr", 32'(memory_trace), 32'h1234);
    check("tmo_acc", 32'(access_count), 32'd6);
    busy_cycles = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!busy) break;
      busy_cycles++;
    end
    check("tmo_busy_cycles", 32'(busy_cycles), 32'd9);
    check("tmo_count", 32'(timeout_count), 32'd1);
    check("tmo_idle", 32'(busy), 32'd0);

    // access_done on the final hold cycle wins over the timeout.
    wr_en = 1'b1; wr_addr = 16'h0055; tick();
    wr_en = 1'b0;
    tick();
    check("prec_acc", 32'(access_count), 32'd7);
    tick();
    for (int i = 0; i < 7; i++) tick();
    check("prec_busy_last", 32'(busy), 32'd1);
    access_done = 1'b1;
    tick();
    access_done = 1'b0;
    check("prec_idle", 32'(busy), 32'd0);
    check("prec_tmo", 32'(timeout_count), 32'd1);

    // Overflow: 17 pushes with start=0, the 17th (0110) is dropped.
    start = 1'b0;
    wr_en = 1'b1;
    for (int i = 0; i < 17; i++) begin
      wr_addr = 16'h0100 + 16'(i);
      tick();
    end
    wr_en = 1'b0;
    check("ovf_full", 32'(full), 32'd1);
    check("ovf_count", 32'(fifo_count), 32'd16);
    check("ovf_empty", 32'(empty), 32'd0);

    // Push concurrent with the pop while full: occupancy stays at 16.
    start = 1'b1;
    wr_en = 1'b1; wr_addr = 16'hBEEF;
    tick();
    wr_en = 1'b0;
    check("pp_count", 32'(fifo_count), 32'd16);
    check("pp_full", 32'(full), 32'd1);
    check("pp_strobe", 32'(new_access), 32'd1);
    check("pp_addr", 32'(memory_trace), 32'h0100);
    check("pp_acc", 32'(access_count), 32'd8);

    // Pause: start dropped during the access; it completes and no further pop follows.
    start = 1'b0;
    tick();
    check("pause_wait", 32'(busy), 32'd1);
    access_done = 1'b1;
    tick();
    access_done = 1'b0;
    check("pause_done", 32'(busy), 32'd0);
    tick(); tick(); tick();
    check("pause_busy", 32'(busy), 32'd0);
    check("pause_count", 32'(fifo_count), 32'd16);
    check("pause_acc", 32'(access_count), 32'd8);
    check("pause_trace", 32'(memory_trace), 32'h0100);

    // Drain: 0101..010F, then BEEF; 0110 never appears.
    start = 1'b1;
    for (int i = 1; i < 16; i++) begin
      serve(16'h0100 + 16'(i), 16'(8 + i));
    end
    serve(16'hBEEF, 16'd24);
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_tmo", 32'(timeout_count), 32'd1);

    // Asynchronous reset mid-WAIT with 3 entries queued.
    start = 1'b0;
    wr_en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      wr_addr = 16'h0A00 + 16'(i);
      tick();
    end
    wr_en = 1'b0;
    start = 1'b1;
    tick();
    tick();
    check("arst_pre_busy", 32'(busy), 32'd1);
    check("arst_pre_count", 32'(fifo_count), 32'd3);
    #2 reset_n = 1'b0;
    #1;
    check("arst_trace", 32'(memory_trace), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_empty", 32'(empty), 32'd1);
    check("arst_count", 32'(fifo_count), 32'd0);
    check("arst_acc", 32'(access_count), 32'd0);
    check("arst_tmo", 32'(timeout_count), 32'd0);
    check("arst_strobe", 32'(new_access), 32'd0);
    #2 reset_n = 1'b1;
    tick();
    tick();
    check("arst_after_busy", 32'(busy), 32'd0);
    check("arst_after_acc", 32'(access_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
